// File: rtl/fpu_addsub_param_if.sv
// Operand/result handshake bundle for fpu_addsub_param.
// The master drives operands and out_ready; the slave (the adder) returns results and flags.
interface fpu_addsub_param_if #(
    parameter int EW = 7,
    parameter int MW = 15
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 op;
    logic signed [EW-1:0] a_e;
    logic signed [EW-1:0] b_e;
    logic        [MW-1:0] a_m;
    logic        [MW-1:0] b_m;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [EW-1:0] res_e;
    logic        [MW-1:0] res_m;
    logic                 res_neg;
    logic                 ovf;
    logic                 unf;

    modport master (
        output in_valid, op, a_e, b_e, a_m, b_m, out_ready,
        input  in_ready, out_valid, res_e, res_m, res_neg, ovf, unf
    );

    modport slave (
        input  in_valid, op, a_e, b_e, a_m, b_m, out_ready,
        output in_ready, out_valid, res_e, res_m, res_neg, ovf, unf
    );
endinterface

// File: rtl/fpu_addsub_param.sv
// Multi-cycle sign-magnitude floating add/subtract: EXP, ALIGN, ARITH, NORM, then DONE until taken.
// Optional macro FPU_ZERO_BYPASS_EN treats a zero mantissa as exact zero and forwards the other operand.
module fpu_addsub_param #(
    parameter int EW = 7,
    parameter int MW = 15
) (
    input logic               clk,
    input logic               reset,
    fpu_addsub_param_if.slave bus
);
    localparam int SW = $clog2(MW + 2);
    localparam logic signed [EW-1:0] E_MAX   = {1'b0, {(EW-1){1'b1}}};
    localparam logic signed [EW-1:0] E_MIN   = {1'b1, {(EW-1){1'b0}}};
    localparam logic signed [EW+1:0] E_MIN_X = {{3{1'b1}}, {(EW-1){1'b0}}};
    localparam logic [EW:0]          D_CAP   = (EW+1)'(MW + 1);
    localparam logic [SW-1:0]        SH_CAP  = SW'(MW + 1);

    typedef enum logic [2:0] {IDLE, EXP, ALIGN, ARITH, NORM, DONE} state_t;

    state_t state;
    state_t state_nxt;

    function automatic logic [SW-1:0] lead_zeros(input logic [MW-1:0] v);
        lead_zeros = SW'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) lead_zeros = SW'(MW - 1 - i);
    endfunction

    // Saturating exponent increment: returns {overflow, new exponent}.
    function automatic logic [EW:0] exp_inc_sat(input logic signed [EW-1:0] e);
        if (e == E_MAX) exp_inc_sat = {1'b1, E_MAX};
        else            exp_inc_sat = {1'b0, EW'(e + 1)};
    endfunction

    logic                 accept;
    logic                 op_q;
    logic signed [EW-1:0] a_e_q;
    logic signed [EW-1:0] b_e_q;
    logic        [MW-1:0] a_m_q;
    logic        [MW-1:0] b_m_q;

    logic                 a_big_p0;
    logic signed [EW-1:0] e_r_p0;
    logic        [SW-1:0] sh_p0;
    logic        [MW-1:0] a_al_p1;
    logic        [MW-1:0] b_al_p1;
    logic        [MW+1:0] mag_p2;
    logic                 neg_p2;

    logic signed [EW-1:0] res_e_q;
    logic        [MW-1:0] res_m_q;
    logic                 res_neg_q;
    logic                 ovf_q;
    logic                 unf_q;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.res_e     = res_e_q;
    assign bus.res_m     = res_m_q;
    assign bus.res_neg   = res_neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = EXP;
            EXP:     state_nxt = ALIGN;
            ALIGN:   state_nxt = ARITH;
            ARITH:   state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // EXP: exponent difference at EW+1 bits, capped shift distance
    logic signed [EW:0]   d;
    logic        [EW:0]   d_abs;
    logic        [SW-1:0] sh;

    assign d     = {a_e_q[EW-1], a_e_q} - {b_e_q[EW-1], b_e_q};
    assign d_abs = d[EW] ? -d : d;
    assign sh    = (d_abs > D_CAP) ? SH_CAP : SW'(d_abs);

    // ARITH: a_aligned +/- b_aligned, magnitude plus sign
    logic [MW+1:0] a_x;
    logic [MW+1:0] b_x;
    logic [MW+1:0] raw;
    logic [MW+1:0] mag;
    logic          neg;

    assign a_x = {2'b00, a_al_p1};
    assign b_x = {2'b00, b_al_p1};
    assign raw = op_q ? (a_x - b_x) : (a_x + b_x);
    assign neg = op_q & raw[MW+1];
    assign mag = neg ? -raw : raw;

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.op;
            a_e_q <= bus.a_e;
            b_e_q <= bus.b_e;
            a_m_q <= bus.a_m;
            b_m_q <= bus.b_m;
        end
        if (state == EXP) begin
            a_big_p0 <= !d[EW];
            e_r_p0   <= d[EW] ? b_e_q : a_e_q;
            sh_p0    <= sh;
        end
        if (state == ALIGN) begin
            a_al_p1 <= a_big_p0 ? a_m_q : (a_m_q >> sh_p0);
            b_al_p1 <= a_big_p0 ? (b_m_q >> sh_p0) : b_m_q;
        end
        if (state == ARITH) begin
            mag_p2 <= mag;
            neg_p2 <= neg;
        end
    end

    // NORM: carry shift-right or leading-zero shift-left, with exponent range checks
    logic        [SW-1:0] lz;
    logic signed [EW+1:0] e_norm;
    logic        [EW:0]   inc;
    logic signed [EW-1:0] n_e;
    logic        [MW-1:0] n_m;
    logic                 n_neg;
    logic                 n_ovf;
    logic                 n_unf;

    assign lz     = lead_zeros(mag_p2[MW-1:0]);
    assign e_norm = {{2{e_r_p0[EW-1]}}, e_r_p0} - (EW+2)'(lz);
    assign inc    = exp_inc_sat(e_r_p0);

    always_comb begin
        n_e   = E_MIN;
        n_m   = '0;
        n_neg = 1'b0;
        n_ovf = 1'b0;
        n_unf = 1'b0;
        if (mag_p2[MW]) begin
            n_ovf = inc[EW];
            n_e   = inc[EW-1:0];
            n_m   = inc[EW] ? '1 : mag_p2[MW:1];
            n_neg = neg_p2;
        end else if (mag_p2 != '0) begin
            if (e_norm < E_MIN_X) begin
                n_unf = 1'b1;
            end else begin
                n_e   = e_norm[EW-1:0];
                n_m   = mag_p2[MW-1:0] << lz;
                n_neg = neg_p2;
            end
        end
`ifdef FPU_ZERO_BYPASS_EN
        if (a_m_q == '0 || b_m_q == '0) begin
            n_e   = E_MIN;
            n_m   = '0;
            n_neg = 1'b0;
            n_ovf = 1'b0;
            n_unf = 1'b0;
            if (a_m_q != '0) begin
                n_e = a_e_q;
                n_m = a_m_q;
            end else if (b_m_q != '0) begin
                n_e   = b_e_q;
                n_m   = b_m_q;
                n_neg = op_q;
            end
        end
`else
        // Zero mantissas flow through the arithmetic path unchanged.
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_e_q   <= '0;
            res_m_q   <= '0;
            res_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (accept) begin
            res_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (state == NORM) begin
            res_e_q   <= n_e;
            res_m_q   <= n_m;
            res_neg_q <= n_neg;
            ovf_q     <= n_ovf;
            unf_q     <= n_unf;
        end
    end
endmodule
